// File: rtl/conv_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_encoder -- rate-1/2 K=7 convolutional encoder (g0=171, g1=133 octal),
// memory to memory; define CONV_ENC_TAIL_EN for a six-zero-bit tail flush. Rev 1.0
// ---------------------------------------------------------------------------
module conv_encoder #(
  parameter int N_WORDS = 128
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic [6:0]  In_address0,
  output logic        In_ce0,
  input  logic [31:0] In_q0,
  output logic [8:0]  Out_address0,
  output logic        Out_ce0,
  output logic        Out_we0,
  output logic [31:0] Out_d0,
  output logic [31:0] ap_return
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_rd   = 3'd1;
  localparam logic [2:0] c_st_load = 3'd2;
  localparam logic [2:0] c_st_enc  = 3'd3;
  localparam logic [2:0] c_st_done = 3'd5;
`ifdef CONV_ENC_TAIL_EN
  localparam logic [2:0] c_st_tail   = 3'd4;
  localparam logic [8:0] c_tail_addr = 9'(2 * N_WORDS);
`endif

  localparam logic [6:0] c_last_word = 7'(N_WORDS - 1);
  localparam logic [6:0] c_g0        = 7'o171;
  localparam logic [6:0] c_g1        = 7'o133;

  logic [2:0]  state_q, state_d;
  logic [5:0]  enc_q, enc_d;
  logic [6:0]  i_q, i_d;
  logic [4:0]  k_q, k_d;
  logic [31:0] sr_q, sr_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ret_q, ret_d;

  logic        w_bit;
  logic [6:0]  w_win;
  logic [1:0]  w_pair;
  logic [31:0] w_acc_new;
  logic        w_wr;

  // enc_q[5] is the most recent past bit, so the window MSB is the current bit
  always_comb begin
    w_bit  = (state_q == c_st_enc) ? sr_q[0] : 1'b0;
    w_win  = {w_bit, enc_q};
    w_pair = {^(w_win & c_g1), ^(w_win & c_g0)};
    w_acc_new = (k_q[3:0] == 4'd0) ? 32'd0 : acc_q;
    w_acc_new[{k_q[3:0], 1'b0} +: 2] = w_pair;

    w_wr = (state_q == c_st_enc) && (k_q[3:0] == 4'hF);
`ifdef CONV_ENC_TAIL_EN
    w_wr = w_wr || ((state_q == c_st_tail) && (k_q == 5'd5));
`endif
  end

  always_comb begin
    state_d = state_q;
    enc_d   = enc_q;
    i_d     = i_q;
    k_d     = k_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;

    case (state_q)
      c_st_idle: begin
        if (ap_start) begin
          enc_d   = 6'd0;
          i_d     = 7'd0;
          cnt_d   = 32'd0;
          state_d = c_st_rd;
        end
      end
      c_st_rd: begin
        state_d = c_st_load;
      end
      c_st_load: begin
        sr_d    = In_q0;
        k_d     = 5'd0;
        state_d = c_st_enc;
      end
      c_st_enc: begin
        enc_d = {w_bit, enc_q[5:1]};
        sr_d  = {1'b0, sr_q[31:1]};
        acc_d = w_acc_new;
        k_d   = k_q + 5'd1;
        if (w_wr) begin
          cnt_d = cnt_q + 32'd1;
        end
        if (k_q == 5'd31) begin
          if (i_q != c_last_word) begin
            i_d     = i_q + 7'd1;
            state_d = c_st_rd;
          end else begin
`ifdef CONV_ENC_TAIL_EN
            k_d     = 5'd0;
            state_d = c_st_tail;
`else
            state_d = c_st_done;
`endif
          end
        end
      end
`ifdef CONV_ENC_TAIL_EN
      c_st_tail: begin
        enc_d = {1'b0, enc_q[5:1]};
        acc_d = w_acc_new;
        k_d   = k_q + 5'd1;
        if (k_q == 5'd5) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = c_st_done;
        end
      end
`endif
      c_st_done: begin
        state_d = c_st_idle;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase

    // Latch the result on entry to DONE so it is valid alongside ap_done
    if ((state_d == c_st_done) && (state_q != c_st_done)) begin
      ret_d = cnt_d;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= c_st_idle;
      enc_q   <= 6'd0;
      i_q     <= 7'd0;
      k_q     <= 5'd0;
      sr_q    <= 32'd0;
      acc_q   <= 32'd0;
      cnt_q   <= 32'd0;
      ret_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      enc_q   <= enc_d;
      i_q     <= i_d;
      k_q     <= k_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    ap_idle      = (state_q == c_st_idle);
    ap_done      = (state_q == c_st_done);
    ap_ready     = (state_q == c_st_done);
    In_ce0       = (state_q == c_st_rd);
    In_address0  = i_q;
    Out_ce0      = w_wr;
    Out_we0      = w_wr;
    Out_address0 = 9'd0;
    Out_d0       = 32'd0;
    if (w_wr) begin
      Out_d0       = w_acc_new;
      Out_address0 = {1'b0, i_q, k_q[4]};
`ifdef CONV_ENC_TAIL_EN
      if (state_q == c_st_tail) begin
        Out_address0 = c_tail_addr;
      end
`endif
    end
    ap_return = ret_q;
  end

endmodule
`default_nettype wire
